// File: rtl/picorv32_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_test_sequencer
// Purpose  : Sequences the PicoRV32 DV wrapper through a batch of test runs,
//            grading each run and accumulating counts and a result signature.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_test_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1000,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_tests,
    output logic             dut_reset,
    output logic             dut_test_start,
    input  logic             dut_test_done,
    input  logic             dut_test_pass,
    input  logic [31:0]      dut_test_result,
    output logic             busy,
    output logic             all_done,
    output logic [CNT_W-1:0] test_idx,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [31:0]      last_result,
    output logic [31:0]      signature
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RESET  = 3'd1;
    localparam logic [2:0] c_ST_RUN    = 3'd2;
    localparam logic [2:0] c_ST_RECORD = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [1:0] c_GR_PASS    = 2'd0;
    localparam logic [1:0] c_GR_FAIL    = 2'd1;
    localparam logic [1:0] c_GR_TIMEOUT = 2'd2;

    localparam int c_RC_W = $clog2(RST_CYCLES + 1);
    localparam int c_TM_W = $clog2(TIMEOUT + 1);
    localparam logic [c_RC_W-1:0] c_RST_LAST = c_RC_W'(RST_CYCLES - 1);
    localparam logic [c_TM_W-1:0] c_TM_LAST  = c_TM_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_num_tests;
    logic [c_RC_W-1:0] r_rst_cnt;
    logic [c_TM_W-1:0] r_run_timer;
    logic [1:0]        r_grade;
    logic [31:0]       r_result;

    logic [2:0]        w_next_state;
    logic [CNT_W-1:0]  w_idx_inc;
    logic              w_timer_last;

    assign w_idx_inc    = test_idx + CNT_W'(1);
    assign w_timer_last = (r_run_timer == c_TM_LAST);

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (go) begin
                        w_next_state = (num_tests == '0) ? c_ST_DONE : c_ST_RESET;
                    end
                end
                c_ST_RESET: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        w_next_state = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (dut_test_done || w_timer_last) begin
                        w_next_state = c_ST_RECORD;
                    end
                end
                c_ST_RECORD: begin
                    w_next_state = (w_idx_inc == r_num_tests) ? c_ST_DONE : c_ST_RESET;
                end
                default: w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // Control outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= c_ST_IDLE;
            r_num_tests    <= '0;
            r_rst_cnt      <= '0;
            r_run_timer    <= '0;
            r_grade        <= c_GR_PASS;
            r_result       <= '0;
            dut_reset      <= 1'b1;
            dut_test_start <= 1'b0;
            busy           <= 1'b0;
            all_done       <= 1'b0;
            test_idx       <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            timeout_count  <= '0;
            last_result    <= '0;
            signature      <= '0;
        end else begin
            r_state        <= w_next_state;
            dut_reset      <= (w_next_state != c_ST_RUN);
            dut_test_start <= (w_next_state == c_ST_RUN);
            busy           <= (w_next_state == c_ST_RESET) || (w_next_state == c_ST_RUN) ||
                              (w_next_state == c_ST_RECORD);
            all_done       <= (w_next_state == c_ST_DONE);

            if (!abort) begin
                case (r_state)
                    c_ST_IDLE, c_ST_DONE: begin
                        if (go) begin
                            r_num_tests   <= num_tests;
                            r_rst_cnt     <= '0;
                            test_idx      <= '0;
                            pass_count    <= '0;
                            fail_count    <= '0;
                            timeout_count <= '0;
                            last_result   <= '0;
                            signature     <= '0;
                        end
                    end
                    c_ST_RESET: begin
                        r_rst_cnt   <= r_rst_cnt + c_RC_W'(1);
                        r_run_timer <= '0;
                    end
                    c_ST_RUN: begin
                        // Grade and result track every RUN cycle; the final cycle's values stick.
                        r_run_timer <= r_run_timer + c_TM_W'(1);
                        r_result    <= dut_test_result;
                        if (dut_test_done) begin
                            r_grade <= dut_test_pass ? c_GR_PASS : c_GR_FAIL;
                        end else begin
                            r_grade <= c_GR_TIMEOUT;
                        end
                    end
                    c_ST_RECORD: begin
                        test_idx  <= w_idx_inc;
                        r_rst_cnt <= '0;
                        if (r_grade == c_GR_TIMEOUT) begin
                            fail_count    <= fail_count + CNT_W'(1);
                            timeout_count <= timeout_count + CNT_W'(1);
                        end else begin
                            if (r_grade == c_GR_PASS) begin
                                pass_count <= pass_count + CNT_W'(1);
                            end else begin
                                fail_count <= fail_count + CNT_W'(1);
                            end
                            last_result <= r_result;
                            signature   <= {signature[30:0], signature[31]} ^ r_result;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_test_sequencer
// Purpose  : Randomized scoreboard bench for picorv32_test_sequencer with a
//            behavioural wrapper model and batch-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picorv32_test_sequencer;

    localparam int RST_CYCLES = 4;
    localparam int TIMEOUT    = 120;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             go;
    logic             abort;
    logic [CNT_W-1:0] num_tests;
    logic             dut_reset;
    logic             dut_test_start;
    logic             dut_test_done;
    logic             dut_test_pass;
    logic [31:0]      dut_test_result;
    logic             busy;
    logic             all_done;
    logic [CNT_W-1:0] test_idx;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic [CNT_W-1:0] timeout_count;
    logic [31:0]      last_result;
    logic [31:0]      signature;

    picorv32_test_sequencer #(
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk             (clk),
        .resetn          (resetn),
        .go              (go),
        .abort           (abort),
        .num_tests       (num_tests),
        .dut_reset       (dut_reset),
        .dut_test_start  (dut_test_start),
        .dut_test_done   (dut_test_done),
        .dut_test_pass   (dut_test_pass),
        .dut_test_result (dut_test_result),
        .busy            (busy),
        .all_done        (all_done),
        .test_idx        (test_idx),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .timeout_count   (timeout_count),
        .last_result     (last_result),
        .signature       (signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        bit          pass;
        logic [31:0] res;
    } run_t;

    typedef struct {
        logic [CNT_W-1:0] idx;
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] f;
        logic [CNT_W-1:0] t;
        logic [31:0]      last;
        logic [31:0]      sig;
    } exp_t;

    run_t stage_q[$];
    run_t run_q[$];
    exp_t exp_q[$];
    int   dur_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_skip = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not as required", name);
    endtask

    // Wrapper model: done rises in RUN cycle 'lat' (0-based) and holds until start drops.
    initial begin
        run_t cur;
        int   cyc;
        bit   in_run;
        cur = '{lat: 100000, pass: 1'b0, res: 32'h0};
        cyc = 0;
        in_run = 1'b0;
        dut_test_done   = 1'b0;
        dut_test_pass   = 1'b0;
        dut_test_result = 32'h0;
        forever begin
            @(negedge clk);
            if (dut_test_start === 1'b1) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    cyc = 0;
                    if (run_q.size() > 0) cur = run_q.pop_front();
                    else cur = '{lat: 100000, pass: 1'b0, res: 32'h0};
                end else begin
                    cyc++;
                end
                dut_test_done   = (cyc >= cur.lat);
                dut_test_pass   = (cyc >= cur.lat) ? cur.pass : 1'($urandom);
                dut_test_result = (cyc >= cur.lat) ? cur.res : $urandom;
            end else begin
                in_run = 1'b0;
                dut_test_done   = 1'b0;
                dut_test_pass   = 1'($urandom);
                dut_test_result = $urandom;
            end
        end
    end

    // Monitor: run lengths, reset gaps, reset/start exclusivity and batch results.
    initial begin
        int run_len;
        int gap;
        bit first;
        bit prev_start;
        bit prev_done;
        exp_t e;
        run_len = 0;
        gap = 0;
        first = 1'b1;
        prev_start = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) check("reset_vs_start", {31'b0, dut_reset}, {31'b0, ~dut_test_start});

            if (dut_test_start === 1'b1) begin
                run_len++;
            end else begin
                if (prev_start && !mon_skip) begin
                    if (dur_q.size() == 0) flag_fail("run_unexpected");
                    else check("run_len", run_len, dur_q.pop_front());
                end
                run_len = 0;
            end

            if (busy !== 1'b1) begin
                gap = 0;
                first = 1'b1;
            end else if (dut_test_start === 1'b1 && !prev_start) begin
                if (!mon_skip) check("reset_gap", gap, first ? RST_CYCLES : RST_CYCLES + 1);
                gap = 0;
                first = 1'b0;
            end else if (dut_test_start !== 1'b1) begin
                gap++;
            end

            if (all_done === 1'b1 && !prev_done && !mon_skip) begin
                if (exp_q.size() == 0) begin
                    flag_fail("done_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("test_idx", test_idx, e.idx);
                    check("pass_count", pass_count, e.p);
                    check("fail_count", fail_count, e.f);
                    check("timeout_count", timeout_count, e.t);
                    check("last_result", last_result, e.last);
                    check("signature", signature, e.sig);
                    check("busy_in_done", {31'b0, busy}, 32'd0);
                end
            end
            prev_start = (dut_test_start === 1'b1);
            prev_done  = (all_done === 1'b1);
        end
    end

    task automatic queue_run(input int lat, input bit pass, input logic [31:0] res);
        stage_q.push_back('{lat: lat, pass: pass, res: res});
    endtask

    // Reference model: grade each staged run from its latency against the timeout.
    task automatic launch(input int n);
        exp_t e;
        e = '{idx: CNT_W'(n), p: '0, f: '0, t: '0, last: 32'h0, sig: 32'h0};
        foreach (stage_q[i]) begin
            if (stage_q[i].lat <= TIMEOUT - 1) begin
                if (stage_q[i].pass) e.p++;
                else e.f++;
                e.last = stage_q[i].res;
                e.sig  = {e.sig[30:0], e.sig[31]} ^ stage_q[i].res;
                dur_q.push_back(stage_q[i].lat + 1);
            end else begin
                e.f++;
                e.t++;
                dur_q.push_back(TIMEOUT);
            end
            run_q.push_back(stage_q[i]);
        end
        stage_q.delete();
        exp_q.push_back(e);
        @(posedge clk); #1;
        go = 1'b1;
        num_tests = CNT_W'(n);
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (all_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("batch_wait_expired");
    endtask

    task automatic wait_start_rises(input int k, input int budget);
        int  cnt;
        bit  prev;
        cnt = 0;
        prev = (dut_test_start === 1'b1);
        for (int i = 0; i < budget && cnt < k; i++) begin
            @(negedge clk);
            if (dut_test_start === 1'b1 && !prev) cnt++;
            prev = (dut_test_start === 1'b1);
        end
        if (cnt < k) flag_fail("start_wait_expired");
    endtask

    task automatic flush_queues();
        run_q.delete();
        exp_q.delete();
        dur_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sel;
        int lat;
        resetn = 1'b0;
        go = 1'b0;
        abort = 1'b0;
        num_tests = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dut_reset", {31'b0, dut_reset}, 32'd1);
        check("rst_start", {31'b0, dut_test_start}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_all_done", {31'b0, all_done}, 32'd0);
        check("rst_idx", test_idx, 32'd0);
        check("rst_sig", signature, 32'd0);
        check("rst_last", last_result, 32'd0);
        resetn = 1'b1;

        // Zero-length batch from IDLE: DONE one cycle after go, never busy.
        exp_q.push_back('{idx: '0, p: '0, f: '0, t: '0, last: 32'h0, sig: 32'h0});
        @(posedge clk); #1;
        go = 1'b1;
        num_tests = '0;
        @(posedge clk); #1;
        go = 1'b0;
        check("zero_all_done", {31'b0, all_done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("zero_busy", {31'b0, busy}, 32'd0);
            check("zero_start", {31'b0, dut_test_start}, 32'd0);
        end

        // Three passing runs.
        for (int i = 0; i < 3; i++) queue_run(102, 1'b1, 32'h12345678);
        launch(3);
        wait_done(3 * (TIMEOUT + RST_CYCLES + 4) + 20);
        check("pass3_sig_const", signature, 32'h7E8DA368);

        // Three timeouts.
        for (int i = 0; i < 3; i++) queue_run(500, 1'b1, 32'hDEADBEEF);
        launch(3);
        wait_done(3 * (TIMEOUT + RST_CYCLES + 4) + 20);
        check("tmo3_timeouts", timeout_count, 32'd3);

        // Fail on the second run.
        queue_run(102, 1'b1, 32'h12345678);
        queue_run(102, 1'b0, 32'h12345678);
        queue_run(102, 1'b1, 32'h12345678);
        launch(3);
        wait_done(3 * (TIMEOUT + RST_CYCLES + 4) + 20);
        check("fail2_sig_const", signature, 32'h7E8DA368);

        // Abort ten cycles into run 2.
        for (int i = 0; i < 3; i++) queue_run(102, 1'b1, 32'h12345678);
        launch(3);
        wait_start_rises(2, 1000);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        mon_skip = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_start", {31'b0, dut_test_start}, 32'd0);
        check("abort_dut_reset", {31'b0, dut_reset}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_pass", pass_count, 32'd1);
        check("abort_idx", test_idx, 32'd1);
        repeat (2) @(negedge clk);
        flush_queues();
        mon_skip = 1'b0;
        queue_run(30, 1'b1, 32'hA5A5_0001);
        launch(1);
        wait_done(TIMEOUT + RST_CYCLES + 20);

        // Synchronous reset mid-RUN of run 2.
        queue_run(80, 1'b1, 32'h0BAD_F00D);
        queue_run(80, 1'b1, 32'h0BAD_F00D);
        launch(2);
        wait_start_rises(2, 1000);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        mon_skip = 1'b1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mrst_dut_reset", {31'b0, dut_reset}, 32'd1);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_pass", pass_count, 32'd0);
        check("mrst_idx", test_idx, 32'd0);
        check("mrst_sig", signature, 32'd0);
        check("mrst_last", last_result, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        flush_queues();
        mon_skip = 1'b0;

        // Randomized batches, with a stray go while busy that must be ignored.
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: lat = 0;
                    1: lat = TIMEOUT - 1;
                    2: lat = TIMEOUT;
                    default: lat = $urandom_range(1, TIMEOUT + 8);
                endcase
                queue_run(lat, 1'($urandom_range(0, 1)), $urandom);
            end
            launch(n);
            repeat (3) @(negedge clk);
            @(posedge clk); #1;
            go = 1'b1;
            num_tests = CNT_W'(n + 3);
            @(posedge clk); #1;
            go = 1'b0;
            wait_done(n * (TIMEOUT + RST_CYCLES + 4) + 20);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
